fpu_addsub_sequencer: RTL
=========================

// Module: fpu_addsub_sequencer
// PURPOSE
//  Multi-cycle controller for IEEE-754 single-precision add/sub around the external combinational CLA mantissa adder.
//  Accepts two operands on a valid/ready handshake, then runs unpack/swap/align, drives the adder and normalizes.
//  Packs the 32-bit result and returns it on a second handshake.
//  Sits between the FPU op decoder and the result writeback; owns sequencing of the shared mantissa adder.
// PARAMETERS
//  FORMAT_LENGTH              32  operand/result width
//  EXPONENT_LENGTH            8   exponent field width
//  FRACTION_LENGTH            23  fraction field width
//  NORMALIZE_MANTISSA_LENGTH  24  mantissa incl. hidden bit (adder width)
// PORTS
//  clk            in   1   clock, rising edge
//  rst            in   1   synchronous, active-high reset
//  in_valid       in   1   operands valid
//  in_ready       out  1   high only in IDLE
//  op_a           in   32  operand A
//  op_b           in   32  operand B
//  op_sub         in   1   0: A+B, 1: A-B
//  out_valid      out  1   result valid (held until out_ready)
//  out_ready      in   1   consumer accepts result
//  out_result     out  32  packed result
//  out_overflow   out  1   result saturated to signed infinity
//  out_underflow  out  1   result flushed to zero
//  out_invalid    out  1   an input had exponent 255; result is 0x7FC00000
//  busy           out  1   state != IDLE
//  add_man_x      out  24  adder operand x; always the larger magnitude
//  add_man_y      out  24  adder operand y; aligned smaller magnitude
//  add_sign_x     out  1   sign of the operand routed to x
//  add_sign_y     out  1   sign of the operand routed to y
//  add_sub        out  1   equals captured op_sub
//  add_result     in   24  adder magnitude result, |x| +/- |y|
//  add_cout       in   1   adder carry out (effective add overflow)
// BEHAVIOUR
//  Reset: state=IDLE. All outputs 0 except in_ready=1. Adder drive registers are 0. An in-flight op is discarded.
//  FSM: IDLE -> ALIGN -> EXEC -> NORM (1..n cycles) -> PACK -> DONE -> IDLE.
//  IDLE: on in_valid&in_ready, capture op_a, op_b, op_sub; go to ALIGN.
//  ALIGN:
//   - exp==0 is treated as zero: mantissa 0, no hidden bit (denormals flushed).
//   - If either exp==255: out_invalid=1, go to PACK.
//   - Compare {exp,frac}. The larger goes to x; on a tie, A goes to x.
//   - y is right-shifted by the exponent difference; shifted-out bits are truncated; diff>=24 gives y=0.
//   - Register add_* outputs.
//   - Result sign: sign_a if unswapped, else sign_b^op_sub.
//  EXEC: add_* stable; capture add_result, add_cout and exp_large; go to NORM.
//  NORM, one action per cycle, in priority order:
//   1. cout=1: mant={1,mant[23:1]}, exp+1, go to PACK.
//   2. mant==0: result +0, go to PACK (exact cancellation is always +0).
//   3. mant[23]=1: go to PACK.
//   4. exp==1: flush to signed zero, out_underflow=1, go to PACK.
//   5. Else mant<<=1, exp-1, stay in NORM.
//  PACK:
//   - exp>=255 after increment: {sign,8'hFF,23'h0}, out_overflow=1.
//   - Else {sign,exp,mant[22:0]}.
//   - Register out_*; go to DONE.
//  DONE: out_valid=1 and out_result/flags held stable until out_ready. On out_valid&out_ready go to IDLE, clear out_valid and flags.
//  Rounding: truncation only.
//  Latency (accepting edge = E0):
//   - out_valid rises at edge E0+4+k, where k = NORM left shifts.
//   - Invalid inputs: out_valid rises at E0+3.
//   - Next accept is no earlier than the cycle after the output handshake.
//  in_valid while busy: ignored; the operand is held upstream.
//  Reset mid-op: the next edge returns to IDLE; no out_valid pulse for the aborted op.
// TESTING
//  1. 3F800000+3F800000 -> 40000000; cout path; out_valid at E0+4.
//  2. 40400000-3F800000 -> 40000000; 3F800000-40400000 -> C0000000 (swap, sign from B^op_sub).
//  3. 3FC00000-3FA00000 -> 3E800000 with k=2: out_valid at E0+6. 3F800000-3F800000 -> 00000000.
//  4. 7F7FFFFF+7F7FFFFF -> 7F800000, out_overflow=1.
//     3F800000+33000000 -> 3F800000 (diff>=24).
//     7F800000+3F800000 -> 7FC00000, out_invalid=1 at E0+3.
//  5. Hold out_ready=0 for 10 cycles: result and flags stable; in_ready=0; a second in_valid is not accepted.
//  6. Assert rst while in NORM: next cycle in_ready=1, busy=0, out_valid=0. The following op completes correctly.

Source files
------------

// File: rtl/fpu_addsub_sequencer.sv
// Sequences one IEEE-754 single-precision add/sub through the shared external mantissa adder.
// Latency: out_valid 4+k edges after accept (k = normalize left shifts), 3 edges for NaN/Inf inputs.
// Backpressure: in_ready only in IDLE; the result and flags are held in DONE until out_ready.
//
// Ports: clk/rst (sync, active-high); in_valid/in_ready/op_a/op_b/op_sub operand handshake;
//        out_valid/out_ready/out_result/out_overflow/out_underflow/out_invalid result handshake;
//        busy; add_man_x/add_man_y/add_sign_x/add_sign_y/add_sub drive the adder, add_result/add_cout return.
module fpu_addsub_sequencer #(
    parameter int FORMAT_LENGTH             = 32,
    parameter int EXPONENT_LENGTH           = 8,
    parameter int FRACTION_LENGTH           = 23,
    parameter int NORMALIZE_MANTISSA_LENGTH = 24
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [FORMAT_LENGTH-1:0]             op_a,
    input  logic [FORMAT_LENGTH-1:0]             op_b,
    input  logic                                 op_sub,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [FORMAT_LENGTH-1:0]             out_result,
    output logic                                 out_overflow,
    output logic                                 out_underflow,
    output logic                                 out_invalid,
    output logic                                 busy,
    output logic [NORMALIZE_MANTISSA_LENGTH-1:0] add_man_x,
    output logic [NORMALIZE_MANTISSA_LENGTH-1:0] add_man_y,
    output logic                                 add_sign_x,
    output logic                                 add_sign_y,
    output logic                                 add_sub,
    input  logic [NORMALIZE_MANTISSA_LENGTH-1:0] add_result,
    input  logic                                 add_cout
);
    localparam int EL = EXPONENT_LENGTH;
    localparam int FL = FRACTION_LENGTH;
    localparam int ML = NORMALIZE_MANTISSA_LENGTH;

    localparam logic [EL:0]              EXP_ONE = (EL+1)'(1);
    localparam logic [EL:0]              EXP_MAX = {1'b0, {EL{1'b1}}};
    localparam logic [FORMAT_LENGTH-1:0] QNAN    = {1'b0, {EL{1'b1}}, 1'b1, {(FL-1){1'b0}}};

    typedef enum logic [2:0] {S_IDLE, S_ALIGN, S_EXEC, S_NORM, S_PACK, S_DONE} state_t;
    state_t state, state_nxt;

    logic [FORMAT_LENGTH-1:0] a_q, b_q;
    logic                     sub_q;
    logic [EL:0]              exp_q;      // one spare bit so exponent 254+1 is visible in PACK
    logic [ML-1:0]            mant_q;
    logic                     cout_q, sign_q, unf_q, inv_q;

    // Unpack and align (combinational view of the captured operands)
    logic [EL-1:0] exp_a, exp_b, exp_x, exp_y, diff;
    logic [ML-1:0] man_a, man_b, man_x, man_y, man_y_sh;
    logic          swap, in_inv;

    always_comb begin
        exp_a    = a_q[FL +: EL];
        exp_b    = b_q[FL +: EL];
        // Zero exponent means zero here: denormals are flushed, no hidden bit
        man_a    = (exp_a == '0) ? '0 : {1'b1, a_q[FL-1:0]};
        man_b    = (exp_b == '0) ? '0 : {1'b1, b_q[FL-1:0]};
        in_inv   = (exp_a == '1) || (exp_b == '1);
        // Strictly larger B swaps; on a magnitude tie A stays in x
        swap     = b_q[FORMAT_LENGTH-2:0] > a_q[FORMAT_LENGTH-2:0];
        exp_x    = swap ? exp_b : exp_a;
        exp_y    = swap ? exp_a : exp_b;
        man_x    = swap ? man_b : man_a;
        man_y    = swap ? man_a : man_b;
        diff     = exp_x - exp_y;
        man_y_sh = (diff >= EL'(ML)) ? '0 : (man_y >> diff);
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (in_valid) state_nxt = S_ALIGN;
            S_ALIGN: state_nxt = S_EXEC;
            // NaN/Inf ops ride through EXEC without using the adder result, then skip NORM
            S_EXEC:  state_nxt = inv_q ? S_PACK : S_NORM;
            S_NORM:  if (cout_q || (mant_q == '0) || mant_q[ML-1] || (exp_q == EXP_ONE))
                         state_nxt = S_PACK;
            S_PACK:  state_nxt = S_DONE;
            S_DONE:  if (out_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Outputs decoded from state
    always_comb begin
        in_ready  = (state == S_IDLE);
        busy      = (state != S_IDLE);
        out_valid = (state == S_DONE);
    end

    // Datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q           <= '0;
            b_q           <= '0;
            sub_q         <= 1'b0;
            exp_q         <= '0;
            mant_q        <= '0;
            cout_q        <= 1'b0;
            sign_q        <= 1'b0;
            unf_q         <= 1'b0;
            inv_q         <= 1'b0;
            add_man_x     <= '0;
            add_man_y     <= '0;
            add_sign_x    <= 1'b0;
            add_sign_y    <= 1'b0;
            add_sub       <= 1'b0;
            out_result    <= '0;
            out_overflow  <= 1'b0;
            out_underflow <= 1'b0;
            out_invalid   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (in_valid) begin
                    a_q   <= op_a;
                    b_q   <= op_b;
                    sub_q <= op_sub;
                    unf_q <= 1'b0;
                    inv_q <= 1'b0;
                end
                S_ALIGN: begin
                    if (in_inv) begin
                        inv_q <= 1'b1;
                    end else begin
                        add_man_x  <= man_x;
                        add_man_y  <= man_y_sh;
                        add_sign_x <= swap ? b_q[FORMAT_LENGTH-1] : a_q[FORMAT_LENGTH-1];
                        add_sign_y <= swap ? a_q[FORMAT_LENGTH-1] : b_q[FORMAT_LENGTH-1];
                        add_sub    <= sub_q;
                        // Swapped means the result is -(B op A), so B's effective sign wins
                        sign_q     <= swap ? (b_q[FORMAT_LENGTH-1] ^ sub_q) : a_q[FORMAT_LENGTH-1];
                        exp_q      <= {1'b0, exp_x};
                    end
                end
                S_EXEC: begin
                    mant_q <= add_result;
                    cout_q <= add_cout;
                end
                S_NORM: begin
                    if (cout_q) begin
                        mant_q <= {1'b1, mant_q[ML-1:1]};
                        exp_q  <= exp_q + EXP_ONE;
                        cout_q <= 1'b0;
                    end else if (mant_q == '0) begin
                        sign_q <= 1'b0;          // exact cancellation is +0
                        exp_q  <= '0;
                    end else if (mant_q[ML-1]) begin
                        exp_q  <= exp_q;
                    end else if (exp_q == EXP_ONE) begin
                        exp_q  <= '0;            // would go denormal: flush to signed zero
                        mant_q <= '0;
                        unf_q  <= 1'b1;
                    end else begin
                        mant_q <= mant_q << 1;
                        exp_q  <= exp_q - EXP_ONE;
                    end
                end
                S_PACK: begin
                    if (inv_q) begin
                        out_result  <= QNAN;
                        out_invalid <= 1'b1;
                    end else if (exp_q >= EXP_MAX) begin
                        out_result   <= {sign_q, {EL{1'b1}}, {FL{1'b0}}};
                        out_overflow <= 1'b1;
                    end else begin
                        out_result    <= {sign_q, exp_q[EL-1:0], mant_q[FL-1:0]};
                        out_underflow <= unf_q;
                    end
                end
                S_DONE: if (out_ready) begin
                    out_result    <= '0;
                    out_overflow  <= 1'b0;
                    out_underflow <= 1'b0;
                    out_invalid   <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule
